fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the team's asyn_fifo (winc/wdata/wfull) among NREQ requesters in the write clock domain.
- Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst, muxes its data onto the FIFO write port and honours wfull back-pressure.
- It sits directly in front of the FIFO write side. Its outputs connect straight to winc/wdata.

---
 rtl/fifo_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the single asyn_fifo
// write port (winc/wdata/wfull) among NREQ valid/ready requesters.
// Each grant lasts up to MAX_BURST words. Every grant is preceded by one
// arbitration cycle in IDLE.
// Optional feature: define WRARB_STALL_CNT_EN to add the stall_cnt output.
// stall_cnt counts BURST cycles in which the granted requester is blocked by wfull.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [WIDTH-1:0]      wdata,
  output logic [2:0]            grant_id,
`ifdef WRARB_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  busy
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;
  localparam int   CW       = 5;

  logic          state_q, state_d;
  logic [2:0]    last_q, last_d;
  logic [2:0]    grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  logic             pick_vld;
  logic [2:0]       pick;
  logic             gnt_vld;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  // Round-robin search: first valid requester after the last grant, wrapping.
  // The loop runs downward so the closest candidate is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(last_q) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick     = 3'((int'(last_q) + k) % NREQ);
      end
    end
  end

  // Select the granted requester's valid and data (loop avoids an oversized index).
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == 3'(i)) begin
        gnt_vld  = req_valid[i];
        gnt_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign busy     = (state_q == ST_BURST);
  assign xfer     = busy & gnt_vld & ~wfull;
  assign winc     = xfer;
  assign wdata    = busy ? gnt_data : '0;
  assign grant_id = grant_q;
  assign cnt_inc  = cnt_q + CW'(1);

  // One-hot ready on the granted lane, gated by FIFO back-pressure.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = busy & (grant_q == 3'(i)) & ~wfull;
    end
  end

  // FSM next state: arbitrate in IDLE, count words and end the burst in BURST.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          last_d  = pick;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!gnt_vld) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(MAX_BURST)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset. The pointer starts at NREQ-1 so req0 is searched first.
  always_ff @(posedge wclk) begin
    if (!wrstn) begin
      state_q <= ST_IDLE;
      last_q  <= 3'(NREQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WRARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles where the granted requester waits on wfull.
  always_comb begin
    stall_d = stall_q;
    if (busy && gnt_vld && wfull && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge wclk) begin
    if (!wrstn) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. A transaction-level model predicts
// every output on each falling edge. Directed scenarios pin the model with
// literal expectations, and a randomized phase is checked against the model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, WIDTH = 8, MAX_BURST = 4;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic                  wrstn;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [WIDTH-1:0]      wdata;
  logic [2:0]            grant_id;
  logic                  busy;
`ifdef WRARB_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrstn(wrstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .grant_id(grant_id),
`ifdef WRARB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy));

  int checks = 0, failures = 0;

  // Requester streams: word = base + sequence number; the sequence advances only on accept.
  logic [7:0] base [NREQ];
  int         seq  [NREQ];
  bit         acc  [NREQ];
  always_comb
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = base[i] + 8'(seq[i]);

  // Model state.
  bit m_init = 0, m_busy = 0;
  int m_gid = 0, m_last = NREQ - 1, m_cnt = 0, m_stall = 0;

  int         log_id[$];
  logic [7:0] log_dat[$];
  logic [7:0] fifo_q[$];
  int         busy_cycles = 0;
  bit         fifo_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model, then advance the model by one clock.
  always @(negedge wclk) begin
    logic [NREQ-1:0] e_ready;
    bit              e_winc;
    logic [7:0]      e_data;
    if (m_init) begin
      e_ready = '0; e_winc = 0; e_data = '0;
      if (m_busy) begin
        if (!wfull) e_ready[m_gid] = 1'b1;
        e_winc = req_valid[m_gid] && !wfull;
        e_data = base[m_gid] + 8'(seq[m_gid]);
      end
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("winc", 32'(winc), 32'(e_winc));
      chk("wdata", 32'(wdata), 32'(e_data));
`ifdef WRARB_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
      if (busy) busy_cycles++;
      if (e_winc) begin log_id.push_back(m_gid); log_dat.push_back(e_data); end
    end
    for (int i = 0; i < NREQ; i++) acc[i] = req_valid[i] && req_ready[i];
    if (fifo_mode && winc) fifo_q.push_back(wdata);
    if (!wrstn) begin
      m_init = 1; m_busy = 0; m_gid = 0; m_last = NREQ - 1; m_cnt = 0; m_stall = 0;
    end else if (m_init) begin
      if (m_busy && req_valid[m_gid] && wfull && m_stall < 65535) m_stall++;
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (req_valid[(m_last + k) % NREQ]) begin
            m_gid = (m_last + k) % NREQ; m_last = m_gid; m_busy = 1; m_cnt = 0;
            break;
          end
        end
      end else if (!req_valid[m_gid]) begin
        m_busy = 0;
      end else if (!wfull) begin
        m_cnt++;
        if (m_cnt == MAX_BURST) m_busy = 0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge wclk); #1;
      for (int i = 0; i < NREQ; i++) if (acc[i]) seq[i]++;
      if (fifo_mode) wfull = (fifo_q.size() >= 16);
    end
  endtask

  task automatic clr_logs();
    log_id.delete(); log_dat.delete(); busy_cycles = 0;
  endtask

  task automatic do_reset();
    req_valid = '0; wfull = 1'b0; wrstn = 1'b0;
    step(1);
    wrstn = 1'b1;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    clr_logs();
  endtask

  initial begin
    int n;
    wrstn = 1'b0; req_valid = '0; wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) begin base[i] = 8'(i * 16); seq[i] = 0; end
    step(2);
    wrstn = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_winc", 32'(winc), 32'd0);

    // Single requester: three words then drop.
    do_reset();
    base[0] = 8'hA0;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (seq[0] >= 3) req_valid[0] = 1'b0;
    end
    chk("single_count", 32'(log_dat.size()), 32'd3);
    for (int j = 0; j < 3 && j < log_dat.size(); j++)
      chk("single_word", 32'(log_dat[j]), 32'(8'hA0 + j));
    chk("single_busy_cycles", 32'(busy_cycles), 32'd4);
    chk("single_grant_end", 32'(grant_id), 32'd0);
    chk("single_busy_end", 32'(busy), 32'd0);

    // All requesters continuously valid: order 0,1,2,3,0 with four words each.
    do_reset();
    for (int i = 0; i < NREQ; i++) base[i] = 8'(i * 16);
    req_valid = '1;
    step(30);
    req_valid = '0;
    chk("rr_count_ge17", 32'(log_id.size() >= 17), 32'd1);
    for (int j = 0; j < 17 && j < log_id.size(); j++) begin
      chk("rr_id", 32'(log_id[j]), 32'((j / 4) % NREQ));
      chk("rr_data", 32'(log_dat[j]), 32'(8'((j / 4) % NREQ * 16) + 8'((j / 16) * 4 + j % 4)));
    end

    // wfull stall for five cycles after the second word.
    do_reset();
    base[0] = 8'h10;
    req_valid[0] = 1'b1;
    n = 0;
    while (log_dat.size() < 2 && n < 20) begin step(1); n++; end
    chk("stall_reach2", 32'(log_dat.size()), 32'd2);
    wfull = 1'b1;
    step(5);
    chk("stall_no_write", 32'(log_dat.size()), 32'd2);
    chk("stall_grant", 32'(grant_id), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
`ifdef WRARB_STALL_CNT_EN
    chk("stall_cnt5", 32'(stall_cnt), 32'd5);
`endif
    wfull = 1'b0;
    step(3);
    chk("stall_resume", 32'(log_dat.size()), 32'd4);
    chk("stall_last_word", 32'(log_dat[log_dat.size()-1]), 32'h13);
    req_valid = '0;

    // Reset mid-burst after the first word.
    do_reset();
    req_valid = 4'b0011;
    n = 0;
    while (log_dat.size() < 1 && n < 20) begin step(1); n++; end
    wrstn = 1'b0;
    step(1);
    wrstn = 1'b1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_grant", 32'(grant_id), 32'd0);
    chk("mrst_winc", 32'(winc), 32'd0);
    clr_logs();
    step(4);
    chk("mrst_regrant_seen", 32'(log_id.size() > 0), 32'd1);
    if (log_id.size() > 0) chk("mrst_regrant_id", 32'(log_id[0]), 32'd0);
    req_valid = '0;

    // FIFO of depth 16 in front, req2 streams 20 words, nothing reads.
    do_reset();
    base[2] = 8'h00;
    fifo_q.delete();
    fifo_mode = 1;
    req_valid[2] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step(1);
      if (seq[2] >= 20) req_valid[2] = 1'b0;
    end
    chk("fifo_count", 32'(fifo_q.size()), 32'd16);
    chk("fifo_winc_pulses", 32'(log_dat.size()), 32'd16);
    for (int j = 0; j < 16 && j < fifo_q.size(); j++)
      chk("fifo_word", 32'(fifo_q[j]), 32'(j));
    fifo_mode = 0;
    req_valid = '0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(1);
      for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(3) != 0);
      wfull = ($urandom_range(4) == 0);
      wrstn = ($urandom_range(199) != 0);
      if (log_id.size() > 1000) clr_logs();
    end
    wrstn = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
